sequence_detector_101001: RTL and testbench
===========================================

# sequence_detector_101001

Serial bit-stream pattern detector for the 6-bit sequence 101001, MSB first, with overlapping detection. It also runs a free-running cycle counter with a terminal-count flag. It sits on a 1-bit serial data path and raises a single-cycle pulse for each complete occurrence of the pattern.

## Interface
- WIDTH, 6, width of the free-running cycle counter `o_count`.
- i_clk  input  1  system clock; all logic is on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_data  input  1  serial data bit, sampled on every rising edge of i_clk.
- o_pattern_found  output  1  registered one-cycle pulse per detected 101001.
- o_count  output  WIDTH  free-running cycle counter.
- o_count_end  output  1  high while o_count is all ones (2^WIDTH−1).

## Operation
- The pattern is 1,0,1,0,0,1 in order of arrival. The first bit received is the MSB.
- The detector is a Moore/registered FSM with six prefix states:
  - S0: no match
  - S1: "1"
  - S2: "10"
  - S3: "101"
  - S4: "1010"
  - S5: "10100"
- Transitions, as (state, i_data) -> next state:
  - S0: 0->S0, 1->S1
  - S1: 0->S2, 1->S1
  - S2: 0->S0, 1->S3
  - S3: 0->S4, 1->S1
  - S4: 0->S5, 1->S3
  - S5: 0->S0, 1->S1 (match)
- Overlap is allowed. After a match the FSM goes to S1, because the trailing "1" starts a new candidate.
- o_pattern_found register: loaded with 1 on the edge that takes S5 with i_data=1, and with 0 on every other edge. Back-to-back matches are impossible; the minimum spacing is 5 cycles.
- Counter:
  - o_count increments by 1 every clock when not in reset.
  - It wraps modulo 2^WIDTH (all ones -> 0) with no stall.
  - o_count_end is a combinational decode of the o_count register (o_count == 2^WIDTH−1).
- i_data must be a valid 0/1 at every sampling edge outside reset. X on i_data is a bench error.

## Timing
- Reset, sampled on a rising edge with i_reset=1:
  - FSM goes to S0.
  - o_pattern_found = 0.
  - o_count = 0.
  - o_count_end = 0.
  - Reset has priority over all other updates.
- First edge with i_reset=0: the first i_data bit is consumed and o_count becomes 1.
- Latency: o_pattern_found is high for exactly one clock period, starting just after the edge that samples the final "1" of the pattern. That is a 1-cycle registered latency.
- Reset asserted mid-pattern:
  - The partial match is discarded and o_pattern_found clears on that edge.
  - A pattern straddling the reset is not detected.
- Wrap: o_count_end is high for exactly one cycle every 2^WIDTH cycles. On the following edge o_count is 0 and o_count_end is 0.
- There is no enable or handshake. Every edge consumes one bit.

## Test plan
- Reset: hold i_reset=1 for 3 edges with random i_data -> o_count=0, o_pattern_found=0, o_count_end=0 throughout.
- Single pattern: after reset, drive 1,0,1,0,0,1 then zeros -> exactly one pulse, in the cycle after bit 6 is sampled.
- Overlapping stream: drive 1010010100 1010011 01001 (22 bits) -> pulses after bits 6, 11, 16 and 22, four in total, each one cycle wide.
- Near-miss and self-overlap: drive 1011, 10101001 and 101000 variants.
  - 10101001 -> one pulse, after its last bit (tests S4 on 1 -> S3).
  - 101000 and 1011 -> no pulse.
- Counter wrap (WIDTH=6):
  - After reset, run 70 cycles.
  - o_count_end is high only while o_count=63.
  - o_count reads 0 on the next cycle and continues 1, 2, ...
- Mid-pattern reset: drive 1,0,1,0,0, assert i_reset for one edge, then drive 1 -> no pulse. o_count restarts from 0.

Source files
------------

// File: rtl/sequence_detector_101001.sv
// Serial detector for 101001 (MSB first, overlapping)
// plus a free-running cycle counter with terminal flag.
module sequence_detector_101001 #(
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_data,
  output logic             o_pattern_found,
  output logic [WIDTH-1:0] o_count,
  output logic             o_count_end
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             found_q;
  logic             found_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // State, pulse and counter registers; reset wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S0;
      found_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      found_q <= found_d;
      count_q <= count_d;
    end
  end

  // Prefix-tracking next state for 101001.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0: state_d = i_data ? S1 : S0;
      S1: state_d = i_data ? S1 : S2;
      S2: state_d = i_data ? S3 : S0;
      S3: state_d = i_data ? S1 : S4;
      S4: state_d = i_data ? S3 : S5;
      S5: state_d = i_data ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  // Match pulse and wrapping counter increment.
  always_comb begin
    found_d = (state_q == S5) && i_data;
    count_d = count_q + WIDTH'(1);
  end

  assign o_pattern_found = found_q;
  assign o_count         = count_q;
  assign o_count_end     = &count_q;

endmodule

// File: tb/tb_sequence_detector_101001.sv
// Directed-vector bench with a queue scoreboard
// for sequence_detector_101001.
module tb_sequence_detector_101001;

  localparam int W = 6;

  typedef struct {
    logic         f;
    logic [W-1:0] c;
    logic         e;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         din;
  logic         found;
  logic [W-1:0] cnt;
  logic         cend;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;

  sequence_detector_101001 #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_data         (din),
    .o_pattern_found(found),
    .o_count        (cnt),
    .o_count_end    (cend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One edge of stimulus; expected outputs after it go to the queue.
  task automatic step(input logic r, input logic d, input logic ef);
    exp_t x;
    rst = r;
    din = d;
    if (r) mcnt = 0;
    else mcnt = (mcnt + 1) % (1 << W);
    x.f = ef;
    x.c = W'(mcnt);
    x.e = (mcnt == (1 << W) - 1);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string d, input string p);
    for (int i = 0; i < d.len(); i++)
      step(1'b0, d[i] == 8'h31, p[i] == 8'h31);
  endtask

  // Monitor: one expected entry per cycle, checked mid-period.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (found !== x.f) begin
        errors++;
        $display("FAIL found t=%0t got %b exp %b",
                 $time, found, x.f);
      end
      checks++;
      if (cnt !== x.c) begin
        errors++;
        $display("FAIL count t=%0t got %0d exp %0d",
                 $time, cnt, x.c);
      end
      checks++;
      if (cend !== x.e) begin
        errors++;
        $display("FAIL count_end t=%0t got %b exp %b",
                 $time, cend, x.e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    din = 1'b0;
    #2;
    // reset held 3 edges with random data
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'(($urandom) & 1), 1'b0);
    // single pattern
    run("101001000", "000001000");
    // overlapping stream: pulses after bits 6, 11, 16, 22
    run("1010010100101001101001",
        "0000010000100001000001");
    run("000", "000");
    // near misses and self-overlap
    run("1011", "0000");
    run("000", "000");
    run("10101001", "00000001");
    run("000", "000");
    run("101000", "000000");
    run("000", "000");
    // counter wrap
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70; i++)
      step(1'b0, 1'b0, 1'b0);
    // mid-pattern reset, pattern straddling it is dropped
    run("10100", "00000");
    step(1'b1, 1'b0, 1'b0);
    run("1000", "0000");
    // reset on the edge right after a match clears the pulse
    run("10100", "00000");
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run("00", "00");
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d left exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
